// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port; one word per grant, 3+ cycles per transaction.
// Requesters hold req_valid until req_ack; `define ARB_VGA_PRIORITY_EN gives port 0 absolute priority.
module sdram_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic [DATA_W-1:0]               req_rdata,
  output logic                            mem_req,
  output logic                            mem_write,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_wmask,
  input  logic                            mem_ack,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MW-1:0]     wmask;
  } cmd_t;

  state_t          state, state_nxt;
  cmd_t            cmd_q;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   sel_id;
  logic [GW-1:0]   win_id;
  logic            sel_vld;
  logic            win_vld;
  logic            vga_win;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[GW-1:0];
  endfunction

  // Walk from farthest to nearest so the port closest after last_grant wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req_valid[rr_idx(last_grant, i)]) begin
        sel_vld = 1'b1;
        sel_id  = rr_idx(last_grant, i);
      end
    end
  end

`ifdef ARB_VGA_PRIORITY_EN
  assign vga_win = req_valid[0];
`else
  assign vga_win = 1'b0;
`endif

  assign win_vld = vga_win | sel_vld;
  assign win_id  = vga_win ? '0 : sel_id;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GW'(NUM_PORTS - 1);
      grant_id   <= '0;
      cmd_q      <= '0;
      req_rdata  <= '0;
    end else begin
      if (state == IDLE && win_vld) begin
        grant_id    <= win_id;
        // Priority grants to port 0 leave the rotation of the other ports untouched.
        if (!vga_win) last_grant <= win_id;
        cmd_q.write <= req_write[win_id];
        cmd_q.addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        cmd_q.wdata <= req_wdata[int'(win_id)*DATA_W +: DATA_W];
        cmd_q.wmask <= req_wmask[int'(win_id)*MW +: MW];
      end
      if (state == BUSY && mem_ack) req_rdata <= mem_rdata;
    end
  end

  always_comb begin
    req_ack = '0;
    if (state == DONE) req_ack[grant_id] = 1'b1;
  end

  assign mem_req   = (state == BUSY);
  assign busy      = (state != IDLE);
  assign mem_write = cmd_q.write;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wmask = cmd_q.wmask;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requests, a controller model and a decoupled monitor.
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic               clock = 1'b0;
  logic               reset;
  logic [NP-1:0]      req_valid;
  logic [NP-1:0]      req_write;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*DW-1:0]   req_wdata;
  logic [NP*MW-1:0]   req_wmask;
  logic [NP-1:0]      req_ack;
  logic [DW-1:0]      req_rdata;
  logic               mem_req;
  logic               mem_write;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [MW-1:0]      mem_wmask;
  logic               mem_ack;
  logic [DW-1:0]      mem_rdata;
  logic [1:0]         grant_id;
  logic               busy;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_ack(req_ack), .req_rdata(req_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    logic          chk;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          wr_tab[NP];
  logic [AW-1:0] addr_tab[NP];
  logic [DW-1:0] wd_tab[NP];
  logic [MW-1:0] wm_tab[NP];

  // controller model knobs
  int            ack_delay = 0;
  bit            use_fixed = 0;
  bit            stray = 0;
  logic [DW-1:0] fixed_rd = '0;

  // monitor results
  int            cyc = 0;
  int            ack_count = 0;
  int            ack_cyc[$];
  int            busy_len = 0;
  int            last_busy_len = 0;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return {6'h2A, a} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    wr_tab[p] = wr; addr_tab[p] = a; wd_tab[p] = wd; wm_tab[p] = wm;
    req_write[p]            = wr;
    req_addr[p*AW +: AW]    = a;
    req_wdata[p*DW +: DW]   = wd;
    req_wmask[p*MW +: MW]   = wm;
  endtask

  task automatic expect_txn(input int p, input logic [DW-1:0] rd);
    exp_t e;
    e.port = p; e.wr = wr_tab[p]; e.addr = addr_tab[p]; e.wd = wd_tab[p];
    e.wm = wm_tab[p]; e.chk = !wr_tab[p]; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string name);
    int start;
    int n;
    start = ack_count;
    n = 0;
    while (ack_count == start && n < 60) begin
      cycles(1);
      n++;
    end
    checks++;
    if (ack_count == start) begin
      errors++;
      $display("FAIL %s_timeout: no req_ack within 60 cycles, expected one", name);
    end
  endtask

  task automatic controller_proc();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = use_fixed ? fixed_rd : rd_fn(mem_addr);
        end
        cnt++;
      end else begin
        cnt = 0;
        if (stray) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
          stray     = 0;
        end
      end
    end
  endtask

  task automatic monitor_proc();
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        busy_len = 0;
      end else begin
        if (!mem_req && busy_len != 0) begin
          last_busy_len = busy_len;
          busy_len = 0;
        end
        if (mem_req) begin
          busy_len++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: mem_req with grant_id=%0d, expected no command", grant_id);
          end else begin
            e = exp_q[0];
            if (int'(grant_id) != e.port || mem_write !== e.wr || mem_addr !== e.addr ||
                mem_wdata !== e.wd || mem_wmask !== e.wm) begin
              errors++;
              $display("FAIL mem_cmd: got id=%0d w=%0b a=0x%0h d=0x%0h m=0x%0h, expected id=%0d w=%0b a=0x%0h d=0x%0h m=0x%0h",
                       grant_id, mem_write, mem_addr, mem_wdata, mem_wmask, e.port, e.wr, e.addr, e.wd, e.wm);
            end
          end
        end
        if (req_ack !== '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: req_ack=0x%0h, expected 0", req_ack);
          end else begin
            e = exp_q.pop_front();
            if (req_ack !== (NP'(1) << e.port) || (e.chk && req_rdata !== e.rd)) begin
              errors++;
              $display("FAIL ack: got req_ack=0x%0h rdata=0x%0h, expected port %0d rdata=0x%0h",
                       req_ack, req_rdata, e.port, e.rd);
            end
            ack_count++;
            ack_cyc.push_back(cyc);
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t2[6];
    int t6a[$];
    int base;
    int n;

    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    set_port(0, 1'b0, 26'h000_1000, 32'hA000_0000, 4'hF);
    set_port(1, 1'b0, 26'h000_2040, 32'hA000_0001, 4'hF);
    set_port(2, 1'b0, 26'h000_0100, 32'hA000_0002, 4'hF);
    set_port(3, 1'b0, 26'h3FF_FFFC, 32'hA000_0003, 4'hF);

    fork
      controller_proc();
      monitor_proc();
    join_none

    cycles(2);
    check("reset_mem_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_req_ack", req_ack, 0);
    check("reset_mem_cmd", {mem_write, mem_addr, mem_wdata, mem_wmask}, 0);
    check("reset_req_rdata", req_rdata, 0);
    reset = 1'b0;
    cycles(1);

    // All four ports requesting back to back, ack in the first BUSY cycle.
`ifdef ARB_VGA_PRIORITY_EN
    t2 = '{0, 0, 0, 0, 0, 0};
`else
    t2 = '{0, 1, 2, 3, 0, 1};
`endif
    ack_delay = 0;
    foreach (t2[i]) expect_txn(t2[i], rd_fn(addr_tab[t2[i]]));
    base = ack_cyc.size();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) wait_ack("t2");
    req_valid = '0;
    if (ack_cyc.size() >= base + 6)
      for (int i = 1; i < 6; i++)
        check("t2_spacing", ack_cyc[base+i] - ack_cyc[base+i-1], 3);
    cycles(2);

    // Single read on port 2, ack four cycles after mem_req.
    use_fixed = 1; fixed_rd = 32'hDEAD_BEEF; ack_delay = 4;
    expect_txn(2, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    wait_ack("t1");
    req_valid = '0;
    check("t1_busy_len", last_busy_len, 5);
    use_fixed = 0;
    cycles(2);

    // Write on port 1.
    ack_delay = 1;
    set_port(1, 1'b1, 26'h000_0ABC, 32'h1234_5678, 4'b0101);
    expect_txn(1, '0);
    req_valid = 4'b0010;
    wait_ack("t3");
    req_valid = '0;
    cycles(2);

    // Long stall on port 3, then a stray ack while idle.
    ack_delay = 10;
    expect_txn(3, rd_fn(addr_tab[3]));
    req_valid = 4'b1000;
    wait_ack("t4");
    req_valid = '0;
    check("t4_busy_len", last_busy_len, 11);
    cycles(1);
    stray = 1;
    cycles(4);
    check("stray_busy", busy, 0);
    check("idle_hold_addr", mem_addr, 26'h3FF_FFFC);
    check("idle_mem_req", mem_req, 0);

    // Reset in the middle of a transaction.
    ack_delay = 20;
    expect_txn(0, rd_fn(addr_tab[0]));
    req_valid = 4'b0001;
    n = 0;
    while (!mem_req && n < 20) begin
      cycles(1);
      n++;
    end
    check("t5_mem_req_rise", mem_req, 1);
    cycles(2);
    reset = 1'b1;
    req_valid = '0;
    exp_q.delete();
    cycles(1);
    reset = 1'b0;
    check("t5_mem_req", mem_req, 0);
    check("t5_busy", busy, 0);
    check("t5_req_ack", req_ack, 0);
    cycles(2);
    check("t5_no_ack", req_ack, 0);
    ack_delay = 1;
    expect_txn(0, rd_fn(addr_tab[0]));
    expect_txn(3, rd_fn(addr_tab[3]));
    req_valid = 4'b1001;
    wait_ack("t5a");
    req_valid[0] = 1'b0;
    wait_ack("t5b");
    req_valid = '0;
    cycles(2);

    // Ports 0,1,2 requesting, then port 0 drops out.
`ifdef ARB_VGA_PRIORITY_EN
    t6a = '{0, 0, 0};
`else
    t6a = '{0, 1, 2, 0};
`endif
    foreach (t6a[i]) expect_txn(t6a[i], rd_fn(addr_tab[t6a[i]]));
    req_valid = 4'b0111;
    foreach (t6a[i]) wait_ack("t6a");
    req_valid = 4'b0110;
    for (int k = 0; k < 4; k++) expect_txn(1 + (k % 2), rd_fn(addr_tab[1 + (k % 2)]));
    for (int k = 0; k < 4; k++) wait_ack("t6b");
    req_valid = '0;

    cycles(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
